oled_spi_driver: RTL and testbench

- Free-running SSD1306 128x64 OLED driver over 4-wire write-only SPI.
- After an asynchronous reset it sequences the panel hard-reset pin and sends a fixed 23-byte init command list.
- It then streams the 1024-byte frame buffer forever, fetching each byte from an external pixel store through a 1-cycle-latency address/data read port.
- It sits beside the SPI-slave datapath in the slave top level and displays the received message.

---
 rtl/oled_spi_driver.sv | 164 ++++++++++++++++
 tb/tb_oled_spi_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/oled_spi_driver.sv
// SSD1306 128x64 OLED driver: panel power-up and reset sequencing, a fixed init command
// list, then a continuous stream of the 1024-byte frame buffer over write-only 4-wire SPI.
module oled_spi_driver #(
  parameter int unsigned STARTUP_WAIT = 10000000
) (
  input  logic       clk,
  input  logic       rst_btn,
  output logic       ioSclk,
  output logic       ioSdin,
  output logic       ioCs,
  output logic       ioDc,
  output logic       ioReset,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData
);

  typedef enum logic [1:0] {INIT_POWER, LOAD_INIT_CMD, SEND, LOAD_DATA} state_t;

  localparam logic [4:0]  NUM_CMDS = 5'd23;
  localparam logic [31:0] WAIT1    = 32'(STARTUP_WAIT);
  localparam logic [31:0] WAIT2    = 32'(2 * STARTUP_WAIT);
  localparam logic [31:0] WAIT3    = 32'(3 * STARTUP_WAIT);

  state_t      state_q, state_d;
  logic [31:0] counter_q, counter_d;
  logic [4:0]  cmd_idx_q, cmd_idx_d;
  logic [2:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [7:0]  shift_q, shift_d;
  logic [9:0]  addr_q, addr_d;
  logic        sclk_q, sclk_d;
  logic        sdin_q, sdin_d;
  logic        cs_q, cs_d;
  logic        dc_q, dc_d;
  logic        rst_pin_q, rst_pin_d;

  function automatic logic [7:0] init_cmd(input logic [4:0] idx);
    case (idx)
      5'd0:    init_cmd = 8'hAE;
      5'd1:    init_cmd = 8'h81;
      5'd2:    init_cmd = 8'h7F;
      5'd3:    init_cmd = 8'hA6;
      5'd4:    init_cmd = 8'h20;
      5'd5:    init_cmd = 8'h00;
      5'd6:    init_cmd = 8'hC8;
      5'd7:    init_cmd = 8'h40;
      5'd8:    init_cmd = 8'hA1;
      5'd9:    init_cmd = 8'hA8;
      5'd10:   init_cmd = 8'h3F;
      5'd11:   init_cmd = 8'hD3;
      5'd12:   init_cmd = 8'h00;
      5'd13:   init_cmd = 8'hD5;
      5'd14:   init_cmd = 8'h80;
      5'd15:   init_cmd = 8'hD9;
      5'd16:   init_cmd = 8'h22;
      5'd17:   init_cmd = 8'hDB;
      5'd18:   init_cmd = 8'h20;
      5'd19:   init_cmd = 8'h8D;
      5'd20:   init_cmd = 8'h14;
      5'd21:   init_cmd = 8'hA4;
      5'd22:   init_cmd = 8'hAF;
      default: init_cmd = 8'hE3;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    cmd_idx_d = cmd_idx_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    sclk_d    = sclk_q;
    sdin_d    = sdin_q;
    cs_d      = cs_q;
    dc_d      = dc_q;
    rst_pin_d = rst_pin_q;

    case (state_q)
      INIT_POWER: begin
        if (counter_q == WAIT3) begin
          state_d = LOAD_INIT_CMD;
          cs_d    = 1'b0;
        end else begin
          // ioReset is registered, so it is derived from the value the counter is about to hold
          counter_d = counter_q + 32'd1;
          rst_pin_d = !((counter_d >= WAIT1) && (counter_d < WAIT2));
        end
      end
      LOAD_INIT_CMD: begin
        dc_d      = 1'b0;
        shift_d   = init_cmd(cmd_idx_q);
        cmd_idx_d = cmd_idx_q + 5'd1;
        bit_d     = 3'd7;
        phase_d   = 1'b0;
        state_d   = SEND;
      end
      LOAD_DATA: begin
        dc_d    = 1'b1;
        shift_d = pixelData;
        bit_d   = 3'd7;
        phase_d = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (!phase_q) begin
          sclk_d  = 1'b0;
          sdin_d  = shift_q[bit_q];
          phase_d = 1'b1;
          // Advance two cycles before LOAD_DATA so the 1-cycle pixel read has settled
          if (dc_q && (bit_q == 3'd0)) addr_d = addr_q + 10'd1;
        end else begin
          sclk_d  = 1'b1;
          phase_d = 1'b0;
          if (bit_q == 3'd0) begin
            state_d = (dc_q || (cmd_idx_q == NUM_CMDS)) ? LOAD_DATA : LOAD_INIT_CMD;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      default: state_d = INIT_POWER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q   <= INIT_POWER;
      counter_q <= 32'd0;
      cmd_idx_q <= 5'd0;
      bit_q     <= 3'd7;
      phase_q   <= 1'b0;
      shift_q   <= 8'd0;
      addr_q    <= 10'd0;
      sclk_q    <= 1'b1;
      sdin_q    <= 1'b0;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
      rst_pin_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      cmd_idx_q <= cmd_idx_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      sclk_q    <= sclk_d;
      sdin_q    <= sdin_d;
      cs_q      <= cs_d;
      dc_q      <= dc_d;
      rst_pin_q <= rst_pin_d;
    end
  end

  assign ioSclk       = sclk_q;
  assign ioSdin       = sdin_q;
  assign ioCs         = cs_q;
  assign ioDc         = dc_q;
  assign ioReset      = rst_pin_q;
  assign pixelAddress = addr_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Bench for oled_spi_driver: a random frame buffer feeds the DUT, expected SPI bytes are
// queued from the init list and frame contents, and a bus monitor decodes and scores them.
module tb_oled_spi_driver;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_btn;
  logic       ioSclk, ioSdin, ioCs, ioDc, ioReset;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;

  logic [7:0] mem [1024];
  logic [7:0] cmdList [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                               8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                               8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
  logic [8:0] expQ [$];
  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  oled_spi_driver #(.STARTUP_WAIT(W)) dut (
    .clk(clk),
    .rst_btn(rst_btn),
    .ioSclk(ioSclk),
    .ioSdin(ioSdin),
    .ioCs(ioCs),
    .ioDc(ioDc),
    .ioReset(ioReset),
    .pixelAddress(pixelAddress),
    .pixelData(pixelData)
  );

  always #5 clk = ~clk;

  // Plain synchronous frame-buffer read: data appears one clock after the address
  always @(posedge clk) pixelData <= mem[pixelAddress];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Queue the byte stream the panel should see after a power-up: all commands, then frame order
  task automatic applyStimulus(input int nData);
    for (int i = 0; i < 23; i++) expQ.push_back({1'b0, cmdList[i]});
    for (int i = 0; i < nData; i++) expQ.push_back({1'b1, mem[i % 1024]});
  endtask

  task automatic checkResetValues();
    checkOutput("reset ioSclk", ioSclk, 1);
    checkOutput("reset ioSdin", ioSdin, 0);
    checkOutput("reset ioCs", ioCs, 1);
    checkOutput("reset ioDc", ioDc, 0);
    checkOutput("reset ioReset", ioReset, 1);
    checkOutput("reset pixelAddress", pixelAddress, 0);
  endtask

  task automatic releaseAndCheckPowerUp();
    @(negedge clk);
    rst_btn = 1'b1;
    for (int k = 0; k <= 3 * W + 1; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("powerup ioReset k=%0d", k), ioReset, (k >= W && k < 2 * W) ? 0 : 1);
      checkOutput($sformatf("powerup ioCs k=%0d", k), ioCs, (k > 3 * W) ? 0 : 1);
      checkOutput($sformatf("powerup ioSclk k=%0d", k), ioSclk, 1);
    end
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (expQ.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("expected bytes left at timeout", expQ.size(), 0);
  endtask

  // Bus monitor: decodes bytes on ioSclk rising edges and checks bit-level timing
  initial begin
    logic       prevSclk = 1'b1;
    logic       prevSdin = 1'b0;
    logic [7:0] shiftIn = 8'd0;
    logic [8:0] expItem;
    int         bitCount = 0;
    int         lowLen = 0;
    int         highLen = 0;
    int         lastStart = -1;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst_btn !== 1'b1 || ioCs !== 1'b0) begin
        bitCount  = 0;
        lastStart = -1;
        lowLen    = 0;
        highLen   = 0;
      end else begin
        if (prevSclk && !ioSclk) begin
          if (bitCount == 0) begin
            if (lastStart >= 0) checkOutput("byte period", cycle - lastStart, 17);
            lastStart = cycle;
          end else begin
            checkOutput("sclk high width", highLen, 1);
          end
          lowLen = 0;
        end
        if (!prevSclk && ioSclk) begin
          checkOutput("sclk low width", lowLen, 1);
          checkOutput("sdin stable at rise", ioSdin, prevSdin);
          shiftIn = {shiftIn[6:0], ioSdin};
          bitCount++;
          highLen = 0;
          if (bitCount == 8) begin
            bitCount = 0;
            if (expQ.size() > 0) begin
              expItem = expQ.pop_front();
              checkOutput("byte dc", ioDc, expItem[8]);
              checkOutput("byte value", shiftIn, expItem[7:0]);
            end
          end
        end
        if (ioSclk) highLen++;
        else lowLen++;
      end
      prevSclk = ioSclk;
      prevSdin = ioSdin;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    rst_btn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetValues();

    // Full frame plus a few bytes to cover the address wrap
    applyStimulus(1030);
    releaseAndCheckPowerUp();
    waitDrain(20000);

    // Abort partway through a data byte and confirm a clean restart
    repeat ($urandom_range(3, 12)) @(negedge clk);
    #2 rst_btn = 1'b0;
    #1;
    checkResetValues();
    repeat (5) @(negedge clk);
    #1;
    checkResetValues();
    applyStimulus(40);
    releaseAndCheckPowerUp();
    waitDrain(2000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
